// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the instruction-fetch stage:
//   PC_W / INST_W  - program counter and instruction widths
//   BUBBLE_INST    - instruction word presented while out_valid is 0
//   fetch_state_e  - FETCH (request in flight or about to launch),
//                    HOLD (instruction parked while downstream stalls)
//   fetch_out_t    - the {valid, pc, inst} triple handed to IF/ID
package fetch_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] BUBBLE_INST = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_out_t;

endpackage : fetch_pkg

// File: rtl/fetch_if.sv
// fetch_if
// Instruction-memory request/acknowledge bus.
//   req   - fetch side requests an instruction
//   addr  - word address, held stable while req is high
//   ack   - memory returns data this cycle (may coincide with the
//           first cycle of req)
//   rdata - instruction word, meaningful only while ack is high
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_if;
  import fetch_pkg::*;

  logic              req;
  logic [PC_W-1:0]   addr;
  logic              ack;
  logic [INST_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );

endinterface : fetch_if

// File: rtl/fetch_hold_reg.sv
// fetch_hold_reg
// Single-entry pending register that parks one fetched instruction
// while the downstream stage is stalled.
//   clk, rst_n  - clock, synchronous active-low reset
//   load        - capture load_pc / load_inst, mark entry valid
//   clear       - drop the entry (wins over load)
//   load_pc     - PC of the instruction being parked
//   load_inst   - instruction word being parked
//   valid       - entry holds an instruction
//   pc, inst    - parked PC and instruction
module fetch_hold_reg
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [PC_W-1:0]   load_pc,
  input  logic [INST_W-1:0] load_inst,
  output logic              valid,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] inst
);

  // NOTE: sequential state is written with non-blocking assignments so
  // every register samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // NOTE: only the valid flag is reset; the payload is never read unless
  // valid is set, so resetting it would just add reset fan-out.
  always_ff @(posedge clk) begin
    if (load) begin
      pc   <= load_pc;
      inst <= load_inst;
    end
  end

endmodule : fetch_hold_reg

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage. Keeps the program counter, fetches one
// instruction per memory acknowledge and presents {pc, inst, valid} to
// the IF/ID buffer. Handles downstream stall (instruction parked in a
// pending register) and branch/jump redirect, including a redirect that
// lands while a memory request is still outstanding (that request is
// completed on the bus and its data dropped).
//   clk, rst_n      - clock, synchronous active-low reset
//   stall           - downstream stall; out_* hold their value
//   redirect_valid  - taken branch/jump this cycle (highest priority)
//   redirect_pc     - redirect target
//   imem            - instruction memory bus (master side)
//   out_valid       - out_inst is a real instruction (0 = bubble)
//   out_pc          - PC of out_inst
//   out_inst        - fetched instruction, BUBBLE_INST when not valid
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] PC_STEP  = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  fetch_if.master           imem,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              squash_q, squash_d;
  logic [PC_W-1:0]   squash_addr_q, squash_addr_d;
  fetch_out_t        out_q, out_d;

  logic              hold_load;
  logic              hold_clear;
  logic              hold_valid;
  logic [PC_W-1:0]   hold_pc;
  logic [INST_W-1:0] hold_inst;

  logic              fetching;
  logic              ack_seen;
  logic [PC_W-1:0]   req_addr;

  // A squashed request must keep its original address on the bus until
  // it is acknowledged, even though pc already points at the new target.
  assign req_addr = squash_q ? squash_addr_q : pc_q;
  assign fetching = (state_q == FETCH);
  assign ack_seen = fetching && imem.ack;

  assign imem.req  = rst_n && fetching;
  assign imem.addr = req_addr;

  assign out_valid = out_q.valid;
  assign out_pc    = out_q.pc;
  assign out_inst  = out_q.inst;

  fetch_hold_reg u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (hold_load),
    .clear     (hold_clear),
    .load_pc   (req_addr),
    .load_inst (imem.rdata),
    .valid     (hold_valid),
    .pc        (hold_pc),
    .inst      (hold_inst)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      squash_q      <= 1'b0;
      squash_addr_q <= '0;
      out_q         <= '{valid: 1'b0, pc: '0, inst: BUBBLE_INST};
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      squash_q      <= squash_d;
      squash_addr_q <= squash_addr_d;
      out_q         <= out_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path
  // through the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    squash_d      = squash_q;
    squash_addr_d = squash_addr_q;
    out_d         = out_q;
    hold_load     = 1'b0;
    hold_clear    = 1'b0;

    if (redirect_valid) begin
      pc_d        = redirect_pc;
      hold_clear  = 1'b1;
      out_d.valid = 1'b0;
      out_d.inst  = BUBBLE_INST;
      state_d     = FETCH;
      if (fetching && !imem.ack) begin
        // Request still in flight: remember its address once; a second
        // redirect before the ack only retargets pc.
        squash_d = 1'b1;
        if (!squash_q) begin
          squash_addr_d = req_addr;
        end
      end else begin
        // Either no request, or it retires right now and its data is
        // dropped here.
        squash_d = 1'b0;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (ack_seen && squash_q) begin
            squash_d = 1'b0;
            if (!stall) begin
              out_d.valid = 1'b0;
              out_d.inst  = BUBBLE_INST;
            end
          end else if (ack_seen && !stall) begin
            out_d = '{valid: 1'b1, pc: req_addr, inst: imem.rdata};
            pc_d  = pc_q + PC_STEP;
          end else if (ack_seen) begin
            hold_load = 1'b1;
            state_d   = HOLD;
          end else if (!stall) begin
            out_d.valid = 1'b0;
            out_d.inst  = BUBBLE_INST;
          end
        end
        HOLD: begin
          if (!stall) begin
            out_d      = '{valid: hold_valid, pc: hold_pc, inst: hold_inst};
            hold_clear = 1'b1;
            pc_d       = pc_q + PC_STEP;
            state_d    = FETCH;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed self-checking bench for fetch_unit. dut1 uses RESET_PC=0 and
// a memory with programmable latency; dut2 uses RESET_PC=FFFF_FFFF and a
// zero-wait memory. Both memories return rdata = addr + 32'h100.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut1 stimulus
  logic              rst_n;
  logic              stall;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;

  // dut2 stimulus
  logic              rst2_n;
  logic              stall2;
  logic              out2_valid;
  logic [PC_W-1:0]   out2_pc;
  logic [INST_W-1:0] out2_inst;

  fetch_if bus1 ();
  fetch_if bus2 ();

  // Latency-programmable memory for dut1: ack after lat cycles of req.
  int lat = 1;
  int wait_cnt = 0;
  assign bus1.ack   = bus1.req && (wait_cnt == lat - 1);
  assign bus1.rdata = bus1.addr + 32'h100;
  always @(posedge clk) begin
    if (bus1.req && !bus1.ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  // Zero-wait memory for dut2.
  assign bus2.ack   = bus2.req;
  assign bus2.rdata = bus2.addr + 32'h100;

  fetch_unit dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus1),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut2 (
    .clk            (clk),
    .rst_n          (rst2_n),
    .stall          (stall2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .imem           (bus2),
    .out_valid      (out2_valid),
    .out_pc         (out2_pc),
    .out_inst       (out2_inst)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after
  // the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v,
                           input logic [31:0] pc, input logic [31:0] inst);
    check({tag, "_valid"}, {31'b0, out_valid}, {31'b0, v});
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_inst"}, out_inst, inst);
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0; stall = 1'b0; stall2 = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; lat = 1;
    repeat (2) tick();

    // Reset state
    check_out("reset", 1'b0, 32'h0, 32'h0);
    check("reset_req", {31'b0, bus1.req}, 32'h0);

    // Zero-wait back-to-back fetch
    rst_n = 1'b1;
    #1;
    check("first_req", {31'b0, bus1.req}, 32'h1);
    check("first_addr", bus1.addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("zw", 1'b1, i, 32'h100 + i);
    end

    // Two-cycle latency: bubble / valid alternation
    lat = 2;
    tick(); check("lat2_b0", {31'b0, out_valid}, 32'h0);
    tick(); check_out("lat2_v0", 1'b1, 32'h4, 32'h104);
    tick(); check("lat2_b1", {31'b0, out_valid}, 32'h0);
    tick(); check_out("lat2_v1", 1'b1, 32'h5, 32'h105);

    // Stall for 3 cycles while the ack arrives
    lat = 1; stall = 1'b1;
    #1;
    check("stall_addr", bus1.addr, 32'h6);
    tick();
    check_out("stall_c1", 1'b1, 32'h5, 32'h105);
    check("stall_req_drop", {31'b0, bus1.req}, 32'h0);
    tick(); check_out("stall_c2", 1'b1, 32'h5, 32'h105);
    tick(); check_out("stall_c3", 1'b1, 32'h5, 32'h105);
    stall = 1'b0;
    #1;
    check("hold_release_req", {31'b0, bus1.req}, 32'h0);
    tick(); check_out("pending_out", 1'b1, 32'h6, 32'h106);
    check("after_hold_addr", bus1.addr, 32'h7);
    tick(); check_out("after_hold", 1'b1, 32'h7, 32'h107);

    // Redirect with zero-wait memory
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    check("redir_bubble_valid", {31'b0, out_valid}, 32'h0);
    check("redir_bubble_inst", out_inst, 32'h0);
    redirect_valid = 1'b0;
    #1;
    check("redir_addr", bus1.addr, 32'h40);
    tick(); check_out("redir_target", 1'b1, 32'h40, 32'h140);

    // Redirect to 0x80 while a 3-cycle request to 0x5 is outstanding
    redirect_valid = 1'b1; redirect_pc = 32'h5;
    tick();
    redirect_valid = 1'b0; lat = 3;
    #1;
    check("sq_launch_addr", bus1.addr, 32'h5);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("sq_req_held", {31'b0, bus1.req}, 32'h1);
    check("sq_addr_c1", bus1.addr, 32'h5);
    check("sq_valid_c1", {31'b0, out_valid}, 32'h0);
    tick();
    check("sq_addr_c2", bus1.addr, 32'h5);
    check("sq_ack_c2", {31'b0, bus1.ack}, 32'h1);
    tick();
    check("sq_dropped", {31'b0, out_valid}, 32'h0);
    check("sq_next_addr", bus1.addr, 32'h80);
    lat = 1;
    tick(); check_out("sq_target", 1'b1, 32'h80, 32'h180);

    // dut2: PC wrap and reset in the middle of HOLD
    rst2_n = 1'b1;
    #1;
    check("wrap_first_addr", bus2.addr, 32'hFFFF_FFFF);
    tick();
    check("wrap_out_pc", out2_pc, 32'hFFFF_FFFF);
    check("wrap_out_inst", out2_inst, 32'h0000_00FF);
    check("wrap_second_addr", bus2.addr, 32'h0);
    tick();
    check("wrap_out_pc2", out2_pc, 32'h0);
    check("wrap_out_inst2", out2_inst, 32'h100);
    stall2 = 1'b1;
    tick();
    check("d2_hold_req", {31'b0, bus2.req}, 32'h0);
    check("d2_hold_pc", out2_pc, 32'h0);
    rst2_n = 1'b0;
    tick();
    check("d2_rst_valid", {31'b0, out2_valid}, 32'h0);
    check("d2_rst_req", {31'b0, bus2.req}, 32'h0);
    rst2_n = 1'b1; stall2 = 1'b0;
    #1;
    check("d2_restart_req", {31'b0, bus2.req}, 32'h1);
    check("d2_restart_addr", bus2.addr, 32'hFFFF_FFFF);
    tick();
    check("d2_restart_valid", {31'b0, out2_valid}, 32'h1);
    check("d2_no_stale_pending", out2_pc, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_unit
